// File: rtl/stream_pkg.sv
// Shared constants and types for the 1:2 stream demultiplexer.
// Channel indices, parameter defaults and the per-channel buffer state encoding.
package stream_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 16;
   localparam int NUM_CH    = 2;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register with a wrap-around accept counter.
// The load strobe is only raised by the parent when the slot is empty or draining.
module stream_out_reg
   import stream_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign drain = (state_q == BUF_FULL) && out_ready;

   // Data only moves on load, so a stalled word can never change under the consumer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         BUF_EMPTY: if (load)           state_d = BUF_FULL;
         BUF_FULL:  if (drain && !load) state_d = BUF_EMPTY;
         default:                       state_d = BUF_EMPTY;
      endcase
      if (load) begin
         data_d = load_data;
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      out_valid = (state_q == BUF_FULL);
      out_data  = data_q;
      cnt       = cnt_q;
   end

endmodule

// File: rtl/stream_demux_1to2.sv
// Steers one valid/ready stream to one of two independently buffered outputs.
// Only the ready mux and the load decode live here; buffering is per channel.
module stream_demux_1to2
   import stream_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
   logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;
   logic [NUM_CH-1:0]            ch_valid;
   logic [NUM_CH-1:0]            ch_ready;
   logic [NUM_CH-1:0]            ch_load;
   logic                         accept;

   assign ch_ready[CH0] = out0_ready;
   assign ch_ready[CH1] = out1_ready;

   // in_ready looks only at the selected channel so a stall elsewhere never blocks us.
   always_comb begin
      in_ready     = ~ch_valid[in_sel] | ch_ready[in_sel];
      accept       = in_valid & in_ready;
      ch_load      = '0;
      ch_load[CH0] = accept & (in_sel == CH0);
      ch_load[CH1] = accept & (in_sel == CH1);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      stream_out_reg #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_out_reg (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (ch_load[g]),
         .load_data (in_data),
         .out_data  (ch_data[g]),
         .out_valid (ch_valid[g]),
         .out_ready (ch_ready[g]),
         .cnt       (ch_cnt[g])
      );
   end

   assign out0_data  = ch_data[CH0];
   assign out0_valid = ch_valid[CH0];
   assign out1_data  = ch_data[CH1];
   assign out1_valid = ch_valid[CH1];
   assign cnt0       = ch_cnt[CH0];
   assign cnt1       = ch_cnt[CH1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: a default instance plus a CNT_W=4 twin
// sharing the same stimulus, used to observe counter wrap.
module tb_stream_demux_1to2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_sel, in_valid;
   logic       out0_ready, out1_ready;

   logic        in_ready, out0_valid, out1_valid;
   logic [7:0]  out0_data, out1_data;
   logic [15:0] cnt0, cnt1;

   logic       w_in_ready, w_out0_valid, w_out1_valid;
   logic [7:0] w_out0_data, w_out1_data;
   logic [3:0] w_cnt0, w_cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stream_demux_1to2 #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready),
      .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   stream_demux_1to2 #(.WIDTH(8), .CNT_W(4)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(w_in_ready),
      .out0_data(w_out0_data), .out0_valid(w_out0_valid), .out0_ready(out0_ready),
      .out1_data(w_out1_data), .out1_valid(w_out1_valid), .out1_ready(out1_ready),
      .cnt0(w_cnt0), .cnt1(w_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
      in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
      #3;
      chk("rst_out0_valid", out0_valid, 0);
      chk("rst_out1_valid", out1_valid, 0);
      chk("rst_out0_data",  out0_data, 0);
      chk("rst_out1_data",  out1_data, 0);
      chk("rst_cnt0",       cnt0, 0);
      chk("rst_cnt1",       cnt1, 0);
      chk("rst_in_ready",   in_ready, 1);
      step();
      rst_n = 1'b1;

      // basic routing
      out0_ready = 1'b1; out1_ready = 1'b1;
      drive(1'b1, 1'b0, 8'hA5);
      chk("basic_rdy0", in_ready, 1);
      step();
      chk("basic_v0", out0_valid, 1);
      chk("basic_d0", out0_data, 8'hA5);
      chk("basic_c0", cnt0, 1);
      drive(1'b1, 1'b1, 8'h3C);
      chk("basic_rdy1", in_ready, 1);
      step();
      chk("basic_v1", out1_valid, 1);
      chk("basic_d1", out1_data, 8'h3C);
      chk("basic_c1", cnt1, 1);
      chk("basic_v0_drained", out0_valid, 0);
      drive(1'b0, 1'b0, 8'h00);
      step();

      // full throughput on channel 0
      do_reset();
      out0_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         chk("tput_rdy", in_ready, 1);
         step();
         chk("tput_v", out0_valid, 1);
         chk("tput_d", out0_data, 32'(i));
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("tput_cnt0", cnt0, 16);
      chk("tput_cnt0_w", w_cnt0, 0);
      chk("tput_cnt1", cnt1, 0);

      // stall isolation
      do_reset();
      out0_ready = 1'b0; out1_ready = 1'b0;
      drive(1'b1, 1'b1, 8'h11);
      step();
      chk("stall_v1", out1_valid, 1);
      chk("stall_d1", out1_data, 8'h11);
      drive(1'b1, 1'b1, 8'h55);
      chk("stall_rdy_blocked", in_ready, 0);
      step();
      chk("stall_d1_hold", out1_data, 8'h11);
      chk("stall_c1", cnt1, 1);
      drive(1'b1, 1'b0, 8'h22);
      chk("stall_rdy_other", in_ready, 1);
      step();
      chk("stall_v0", out0_valid, 1);
      chk("stall_d0", out0_data, 8'h22);
      chk("stall_d1_still", out1_data, 8'h11);
      chk("stall_v1_still", out1_valid, 1);
      drive(1'b0, 1'b0, 8'h00);
      step();
      chk("hold_d0", out0_data, 8'h22);
      chk("hold_v0", out0_valid, 1);

      // simultaneous drain and load on channel 0
      out0_ready = 1'b1;
      drive(1'b1, 1'b0, 8'h77);
      chk("dl_rdy", in_ready, 1);
      step();
      chk("dl_v0", out0_valid, 1);
      chk("dl_d0", out0_data, 8'h77);
      chk("dl_c0", cnt0, 2);
      drive(1'b0, 1'b0, 8'h00);
      out1_ready = 1'b1;
      step();
      chk("both_drain_v0", out0_valid, 0);
      chk("both_drain_v1", out1_valid, 0);

      // asynchronous reset mid-cycle while out1 is full
      out1_ready = 1'b0;
      drive(1'b1, 1'b1, 8'h99);
      step();
      chk("arst_pre_v1", out1_valid, 1);
      drive(1'b0, 1'b0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_v0", out0_valid, 0);
      chk("arst_v1", out1_valid, 0);
      chk("arst_d1", out1_data, 0);
      chk("arst_c0", cnt0, 0);
      chk("arst_c1", cnt1, 0);
      step();
      rst_n = 1'b1;
      out1_ready = 1'b1;
      #1;
      chk("arst_rdy", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("arst_no_ghost", out1_valid, 0);
      end

      // counter wrap on the CNT_W=4 twin
      do_reset();
      out1_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         drive(1'b1, 1'b1, 8'(i));
         step();
         chk("wrap_cnt1_w", w_cnt1, 32'(i % 16));
         chk("wrap_cnt0_w", w_cnt0, 0);
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("wrap_cnt1_wide", cnt1, 17);
      chk("wrap_d1", out1_data, 8'd17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
